// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin front end that shares one insert_sort engine
// among NREQ requesters. One vector is accepted per grant and latched onto
// sort_data. The engine gets a single start pulse. The owner's id is then
// presented on rsp_id together with an error flag until the owner consumes
// the result.
//
// Optional feature macro: SORT_ARB_TIMEOUT_EN
//   defined   -> a 16-bit watchdog counts BUSY cycles. After TIMEOUT cycles
//                without done/error, the job ends with rsp_err = 1.
//   undefined -> BUSY waits for the engine indefinitely.
module sort_arbiter #(
  parameter int NREQ           = 4,
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ*INPUTVALS*INPUTBITWIDTHS-1:0] req_data,
  output logic                                     sort_start,
  output logic [INPUTVALS*INPUTBITWIDTHS-1:0]      sort_data,
  input  logic                                     sort_done,
  input  logic                                     sort_error,
  output logic                                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]                  rsp_id,
  output logic                                     rsp_err,
  input  logic                                     rsp_ready,
  output logic                                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int VW  = INPUTVALS * INPUTBITWIDTHS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Reject parameter values outside the supported range at elaboration.
  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("sort_arbiter: NREQ must be 2..16 and TIMEOUT 1..65535");
  end

  // Cyclic index (base + off) mod NREQ. The extra bit keeps the sum exact
  // for any NREQ, including values that are not powers of two.
  function automatic logic [IDW-1:0] cyc_idx(input logic [IDW-1:0] base,
                                             input int unsigned    off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + (IDW+1)'(off);
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  logic [1:0]     state_q,      state_d;
  logic [IDW-1:0] ptr_q,        ptr_d;
  logic [VW-1:0]  sort_data_q,  sort_data_d;
  logic [IDW-1:0] rsp_id_q,     rsp_id_d;
  logic           rsp_err_q,    rsp_err_d;
  logic           pend_err_q,   pend_err_d;
  logic           sort_start_q, sort_start_d;
  logic           rsp_valid_q,  rsp_valid_d;
  logic           busy_q,       busy_d;
`ifdef SORT_ARB_TIMEOUT_EN
  logic [15:0]    wdog_q,       wdog_d;
`endif

  logic [IDW-1:0]  grant_s;
  logic            any_s;
  logic [NREQ-1:0] req_ready_s;
  logic            xfer_s;

  // Round-robin pick: first requester at or after ptr (wrapping) with valid set.
  always_comb begin
    grant_s = '0;
    any_s   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any_s && req_valid[cyc_idx(ptr_q, k)]) begin
        grant_s = cyc_idx(ptr_q, k);
        any_s   = 1'b1;
      end else begin
        any_s   = any_s;
      end
    end
  end

  // One-hot ready, only in IDLE. Also forced low while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    if (state_q == ST_IDLE && any_s && !reset) begin
      req_ready_s[grant_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  assign req_ready = req_ready_s;
  assign xfer_s    = |(req_valid & req_ready_s);

  // Sequencer next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sort_data_d = sort_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    pend_err_d  = pend_err_q;
`ifdef SORT_ARB_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d     = ST_START;
          sort_data_d = req_data[int'(grant_s)*VW +: VW];
          rsp_id_d    = grant_s;
          rsp_err_d   = 1'b0;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
`ifdef SORT_ARB_TIMEOUT_EN
        wdog_d  = 16'd0;
`endif
      end
      ST_BUSY: begin
        // An error outranks a simultaneous done.
        if (sort_error) begin
          state_d   = ST_RESP;
          rsp_err_d = 1'b1;
        end else if (sort_done) begin
          state_d   = ST_RESP;
          rsp_err_d = pend_err_q;
        end else begin
`ifdef SORT_ARB_TIMEOUT_EN
          if (wdog_q >= 16'(TIMEOUT - 1)) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            wdog_d    = wdog_q + 16'd1;
          end
`else
          state_d = ST_BUSY;
`endif
        end
      end
      ST_RESP: begin
        // Engine pulses are ignored here; only the owner's handshake matters.
        if (rsp_ready) begin
          state_d    = ST_IDLE;
          pend_err_d = 1'b0;
          if (rsp_id_q == IDW'(NREQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = rsp_id_q + IDW'(1);
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        // Corrupted state: recover and flag the next job's response.
        state_d    = ST_IDLE;
        pend_err_d = 1'b1;
      end
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    sort_start_d = (state_d == ST_START);
    rsp_valid_d  = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      sort_data_q  <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      pend_err_q   <= 1'b0;
      sort_start_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SORT_ARB_TIMEOUT_EN
      wdog_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sort_data_q  <= sort_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      pend_err_q   <= pend_err_d;
      sort_start_q <= sort_start_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
`ifdef SORT_ARB_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign sort_start = sort_start_q;
  assign sort_data  = sort_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: scenario tasks with a scoreboard of expected responses.
// A background engine model answers each sort_start after eng_lat cycles.
module tb_sort_arbiter;
  localparam int NREQ = 4;
  localparam int IV   = 4;
  localparam int IB   = 8;
  localparam int VW   = IV * IB;
`ifdef SORT_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*VW-1:0] req_data;
  logic               sort_start;
  logic [VW-1:0]      sort_data;
  logic               sort_done;
  logic               sort_error;
  logic               rsp_valid;
  logic [1:0]         rsp_id;
  logic               rsp_err;
  logic               rsp_ready;
  logic               busy;

  sort_arbiter #(.NREQ(NREQ), .INPUTVALS(IV), .INPUTBITWIDTHS(IB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .sort_start(sort_start), .sort_data(sort_data),
    .sort_done(sort_done), .sort_error(sort_error), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int eng_lat   = 5;
  bit eng_err   = 1'b0;
  bit eng_never = 1'b0;
  bit eng_kill  = 1'b0;

  logic [1:0]    exp_id_q[$];
  logic          exp_err_q[$];
  logic [VW-1:0] exp_data_q[$];

  logic [1:0]    e_id;
  logic          e_err;
  logic [VW-1:0] e_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < NREQ; i++) req_data[i*VW +: VW] = $urandom();
  endtask

  function automatic logic [VW-1:0] slice(input int i);
    return req_data[i*VW +: VW];
  endfunction

  task automatic push_exp(input int id, input logic err);
    exp_id_q.push_back(2'(id));
    exp_err_q.push_back(err);
    exp_data_q.push_back(slice(id));
  endtask

  task automatic pop_exp();
    if (exp_id_q.size() > 0) begin
      e_id = exp_id_q.pop_front(); e_err = exp_err_q.pop_front(); e_data = exp_data_q.pop_front();
    end else begin
      e_id = 2'bxx; e_err = 1'bx; e_data = 'x;
    end
  endtask

  // Bounded wait for rsp_valid; reports elapsed cycles and start pulses seen.
  task automatic wait_rsp(input int budget, output int n, output bit ok, output int starts);
    n = 0; ok = 1'b0; starts = 0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (sort_start === 1'b1) starts++;
      tick();
      n++;
    end
  endtask

  // Engine model: done (optionally with error) eng_lat cycles after start.
  initial begin
    sort_done = 1'b0;
    sort_error = 1'b0;
    forever begin
      tick();
      if (sort_start === 1'b1) begin
        eng_kill = 1'b0;
        for (int i = 0; i < eng_lat; i++) begin
          tick();
          if (eng_kill) break;
        end
        if (!eng_kill && !eng_never) begin
          sort_done = 1'b1; sort_error = eng_err;
          tick();
          sort_done = 1'b0; sort_error = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0; fill_data();
    tick(); #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if ({sort_start, rsp_valid, rsp_err, busy} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got start/valid/err/busy=%b want 0000", {sort_start, rsp_valid, rsp_err, busy}); end
    total++; if ({rsp_id, sort_data} !== {2'd0, 32'd0}) begin bad++; $display("FAIL reset_id_data: got id=%0d data=%h want 0/0", rsp_id, sort_data); end
    req_valid = 4'b0000;
    @(negedge clk) reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n, st; bit ok;
    logic [3:0] want;
    fill_data(); req_valid = 4'b1111; rsp_ready = 1'b1; eng_lat = 3;
    for (int j = 0; j < 5; j++) begin
      #1;
      want = 4'b0001 << order[j];
      total++; if (req_ready !== want) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", j, req_ready, want); end
      push_exp(order[j], 1'b0);
      tick();
      if (j == 4) req_valid = 4'b0000;
      wait_rsp(50, n, ok, st);
      total++; if (!ok) begin bad++; $display("FAIL rr_rsp_timeout%0d: got no rsp_valid want rsp_valid", j); end
      total++; if (st != 1) begin bad++; $display("FAIL rr_starts%0d: got %0d want 1", j, st); end
      pop_exp();
      total++; if ({rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL rr_rsp%0d: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", j, rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
      tick();
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    int n, st; bit ok;
    fill_data(); req_valid = 4'b0100; rsp_ready = 1'b0; eng_lat = 20;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    push_exp(2, 1'b0);
    tick(); req_valid = 4'b0000;
    total++; if (sort_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1 at T+1", sort_start); end
    tick();
    wait_rsp(100, n, ok, st);
    total++; if (!ok || (n + 2) != 22) begin bad++; $display("FAIL single_latency: got rsp_valid at T+%0d want T+22", n + 2); end
    total++; if (st != 0) begin bad++; $display("FAIL single_extra_start: got %0d want 0", st); end
    pop_exp();
    total++; if ({rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL single_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_release: got valid/busy=%b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_error();
    int n, st; bit ok;
    fill_data(); req_valid = 4'b1000; eng_lat = 4; eng_err = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL err_grant: got %b want 1000", req_ready); end
    push_exp(3, 1'b1);
    tick(); req_valid = 4'b0000;
    wait_rsp(50, n, ok, st);
    total++; if (!ok) begin bad++; $display("FAIL err_rsp_timeout: got no rsp_valid want rsp_valid"); end
    pop_exp();
    total++; if ({rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL err_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    eng_err = 1'b0;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n, st; bit ok;
    fill_data(); req_valid = 4'b0011; rsp_ready = 1'b0; eng_lat = 5;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
    push_exp(0, 1'b0);
    tick();
    wait_rsp(50, n, ok, st);
    total++; if (!ok) begin bad++; $display("FAIL bp_rsp_timeout: got no rsp_valid want rsp_valid"); end
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if ({rsp_valid, rsp_id, req_ready, busy} !== {1'b1, 2'd0, 4'b0000, 1'b1}) begin bad++; $display("FAIL bp_hold%0d: got valid=%b id=%0d ready=%b busy=%b want 1/0/0000/1", i, rsp_valid, rsp_id, req_ready, busy); end
      tick();
    end
    pop_exp();
    total++; if ({rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL bp_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
    push_exp(1, 1'b0);
    tick(); req_valid = 4'b0000;
    wait_rsp(50, n, ok, st);
    pop_exp();
    total++; if (!ok || {rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL bp_rsp2: got ok=%b id=%0d err=%b data=%h want ok=1 id=%0d err=%b data=%h", ok, rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

`ifdef SORT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, st; bit ok;
    fill_data(); req_valid = 4'b0001; rsp_ready = 1'b0; eng_lat = 15;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL to_grant: got %b want 0001", req_ready); end
    push_exp(0, 1'b1);
    tick(); req_valid = 4'b0000;
    tick();
    wait_rsp(50, n, ok, st);
    total++; if (!ok || n != 8) begin bad++; $display("FAIL to_latency: got %0d BUSY cycles ok=%b want 8", n, ok); end
    for (int i = 0; i < 12; i++) tick();
    total++; if ({rsp_valid, rsp_err, busy} !== 3'b111) begin bad++; $display("FAIL to_late_done: got valid/err/busy=%b want 111", {rsp_valid, rsp_err, busy}); end
    pop_exp();
    total++; if ({rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL to_rsp: got id=%0d err=%b data=%h want id=%0d err=%b data=%h", rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int n, st; bit ok;
    fill_data(); req_valid = 4'b0100; rsp_ready = 1'b0; eng_lat = 30; eng_never = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rm_grant: got %b want 0100", req_ready); end
    tick(); req_valid = 4'b0000;
    repeat (5) tick();
    total++; if ({busy, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rm_waiting: got busy/valid=%b want 10", {busy, rsp_valid}); end
    #2; reset = 1'b1; eng_kill = 1'b1;
    #1;
    total++; if ({req_ready, sort_start, rsp_valid, rsp_err, busy} !== 8'd0) begin bad++; $display("FAIL rm_async_flags: got ready=%b start=%b valid=%b err=%b busy=%b want all 0", req_ready, sort_start, rsp_valid, rsp_err, busy); end
    total++; if ({rsp_id, sort_data} !== {2'd0, 32'd0}) begin bad++; $display("FAIL rm_async_id_data: got id=%0d data=%h want 0/0", rsp_id, sort_data); end
    #4; reset = 1'b0;
    exp_id_q.delete(); exp_err_q.delete(); exp_data_q.delete();
    tick();
    eng_never = 1'b0; eng_lat = 4; req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_next_grant: got %b want 0001", req_ready); end
    push_exp(0, 1'b0);
    tick(); req_valid = 4'b0000;
    wait_rsp(50, n, ok, st);
    pop_exp();
    total++; if (!ok || {rsp_id, rsp_err, sort_data} !== {e_id, e_err, e_data}) begin bad++; $display("FAIL rm_rsp: got ok=%b id=%0d err=%b data=%h want ok=1 id=%0d err=%b data=%h", ok, rsp_id, rsp_err, sort_data, e_id, e_err, e_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_error();
    test_backpressure();
`ifdef SORT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if a scenario ever stalls past its bounds.
  initial begin
    #200000;
    $display("FAIL global_watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_arbiter.md
# sort_arbiter

Round-robin arbiter and sequencer sharing one `insert_sort` engine among `NREQ` requesters. It accepts one vector per grant, latches it, and pulses the engine's start. It then waits for the done flag and presents a response tagged with the owning requester's id. It sits between the request sources and the sort engine. The engine's `sorted` / `sorted_positions` outputs are read directly by the requester named on `rsp_id` while `rsp_valid` is high.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `INPUTVALS`, 16: values per vector; must match the engine.
- `INPUTBITWIDTHS`, 32: bits per value; must match the engine.
- `TIMEOUT`, 255: watchdog limit in cycles, 1..65535. Used only with `SORT_ARB_TIMEOUT_EN`.
- `IDW`: localparam, `$clog2(NREQ)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: requester i has a vector pending.
- `req_ready` out NREQ: one-hot grant; a transfer happens on `req_valid[i] & req_ready[i]`.
- `req_data` in NREQ*INPUTVALS*INPUTBITWIDTHS: packed vectors; requester i occupies slice i.
- `sort_start` out 1: one-cycle start pulse to the engine.
- `sort_data` out INPUTVALS*INPUTBITWIDTHS: registered vector driven to the engine's `needs_sorting`.
- `sort_done` in 1: engine done pulse.
- `sort_error` in 1: engine FSM error pulse.
- `rsp_valid` out 1: result available on the engine outputs.
- `rsp_id` out IDW: owner of the current result.
- `rsp_err` out 1: the job ended in error or timeout; qualified by `rsp_valid`.
- `rsp_ready` in 1: the owner has consumed the result.
- `busy` out 1: high in every state other than IDLE.

## Operation
The block is an FSM with four states: IDLE, START, BUSY and RESP.

- **IDLE**
  - Grant goes to the lowest i ≥ `ptr` (cyclic) with `req_valid[i]` set.
  - `req_ready` is combinational: `req_ready[grant] = 1` only in IDLE and only when some `req_valid` is high.
  - On transfer: latch `req_data[grant]` into `sort_data`, latch `grant` into `rsp_id`, go to START.
- **START**
  - `sort_start = 1` for exactly one cycle, then go to BUSY.
  - Clear the watchdog counter.
- **BUSY**
  - `sort_done` → RESP with `rsp_err = 0`.
  - `sort_error` → RESP with `rsp_err = 1`. If both pulse in the same cycle, error wins.
- **RESP**
  - `rsp_valid = 1`; `rsp_id` and `rsp_err` are held stable.
  - On `rsp_ready` → IDLE, with `ptr <= (rsp_id + 1) mod NREQ`.
  - `sort_done` / `sort_error` pulses arriving in RESP are ignored.
- **Fairness:** a requester that keeps `req_valid` asserted waits at most NREQ−1 other jobs.
- **Data stability:** `sort_data` changes only on an IDLE transfer.
- **Vector ordering:** `req_data` slice i is bits `[(i+1)*INPUTVALS*INPUTBITWIDTHS-1 : i*INPUTVALS*INPUTBITWIDTHS]`. Element ordering within a slice matches the engine's packed array.
- **Illegal state encoding:** return to IDLE and set `rsp_err = 1` for the next job's response.

## Timing
- **Reset values:** `req_ready = 0`, `sort_start = 0`, `sort_data = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_err = 0`, `busy = 0`. Also `ptr = 0` and state IDLE.
- **Request latency:** transfer in cycle T gives `sort_start` in cycle T+1. `sort_done` in cycle D gives `rsp_valid` from cycle D+1.
- **Response latency:**
  - `rsp_ready` may already be high on the first `rsp_valid` cycle; the arbiter is then back in IDLE the next cycle.
  - A new grant is possible one cycle after the response handshake.
  - Minimum job overhead is 3 cycles plus the engine time.
- **Deasserted request:** `req_valid` dropping before the transfer is legal; no job is taken.
- **Reset mid-job:** the arbiter returns immediately to IDLE and drops the response. The engine must share the same reset.

## Configuration
- **`SORT_ARB_TIMEOUT_EN` defined:** a 16-bit counter increments each BUSY cycle.
  - When it reaches `TIMEOUT` with no `sort_done` or `sort_error`, go to RESP with `rsp_err = 1`.
  - The engine is not re-pulsed; a late `sort_done` is ignored.
- **Not defined:** the counter logic is absent, and BUSY waits indefinitely.

## Test plan
- **Single job:** req_valid = 4'b0100 with data; engine model returns done 20 cycles after start. Expect `req_ready = 4'b0100` in cycle T, `sort_start` at T+1, `rsp_valid` with `rsp_id = 2` and `rsp_err = 0` at T+22, and `sort_data` equal to slice 2.
- **Round robin:** all four req_valid held high, `rsp_ready = 1`. Expect grant order 0,1,2,3,0 and exactly one `sort_start` per job.
- **Backpressure:** `rsp_ready = 0` for 10 cycles after done. Expect `rsp_valid`/`rsp_id` held, no new `req_ready`, and `busy = 1`. After `rsp_ready` is raised, the next grant appears on the following cycle.
- **Engine error:** `sort_error` and `sort_done` pulse together in BUSY. Expect `rsp_err = 1`.
- **Timeout:** with the macro defined and `TIMEOUT = 8`, `sort_done` is never asserted. Expect `rsp_valid` with `rsp_err = 1` after 8 BUSY cycles. A late `sort_done` is ignored.
- **Reset mid-job:** `reset` pulsed in BUSY for half a cycle, asynchronously. Expect all outputs at reset values immediately, `ptr = 0`, and the next grant going to requester 0.
